// File: rtl/axi_cdma_desc_demux_pkg.sv
// Shared definitions for the CDMA descriptor demux / status merge block.
// Holds the engine status error codes and the helpers used to size
// status entries and the engine select field.
package axi_cdma_desc_demux_pkg;

  // Width of the error field in every engine status word.
  localparam int STATUS_ERR_WIDTH = 4;

  // Engine status error codes. Zero always means the transfer completed.
  localparam logic [STATUS_ERR_WIDTH-1:0] DMA_ERROR_NONE          = 4'd0;
  localparam logic [STATUS_ERR_WIDTH-1:0] DMA_ERROR_TIMEOUT       = 4'd1;
  localparam logic [STATUS_ERR_WIDTH-1:0] DMA_ERROR_PARITY        = 4'd2;
  localparam logic [STATUS_ERR_WIDTH-1:0] DMA_ERROR_AXI_RD_SLVERR = 4'd4;
  localparam logic [STATUS_ERR_WIDTH-1:0] DMA_ERROR_AXI_RD_DECERR = 4'd5;
  localparam logic [STATUS_ERR_WIDTH-1:0] DMA_ERROR_AXI_WR_SLVERR = 4'd6;
  localparam logic [STATUS_ERR_WIDTH-1:0] DMA_ERROR_AXI_WR_DECERR = 4'd7;

  // A queued status entry is {tag, error}.
  function automatic int status_entry_width(input int tag_width);
    return tag_width + STATUS_ERR_WIDTH;
  endfunction

  // Select field width: enough bits to name every engine, never zero.
  function automatic int sel_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/axi_cdma_status_fifo.sv
// Per-engine status FIFO: valid-only write side, popped by the merge arbiter.
// Latency: a write at edge N is visible (not empty) after edge N; read data is combinational.
// Backpressure: none on the write side; a write into a full FIFO without a same-cycle pop is dropped and overflow pulses next cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (pointers and overflow only)
//   wr_vld, wr_dat  status entry in, no ready
//   rd_en, rd_dat   pop strobe and head-of-queue data
//   empty, full     occupancy flags
//   overflow        one-cycle pulse, the cycle after an entry was lost
module axi_cdma_status_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty; pointers wrap freely.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_do;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_dat   = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;

  always_comb begin
    rd_do      = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write while full still lands.
    wr_en      = wr_vld && (!full || rd_do);
    overflow_d = wr_vld && full && !rd_do;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_do) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end
  end

endmodule

// File: rtl/axi_cdma_desc_demux.sv
// Descriptor demux to PORTS CDMA engines plus round-robin merge of their status streams.
// Latency: descriptor accept -> m_axis_desc_valid 1 cycle; engine status N -> merged status N+2.
// Backpressure: registered s_axis_desc_ready driven by the selected engine via a two-entry skid; status has none (per-engine FIFO, overflow counted).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_axis_desc_*                 descriptor in {read_addr, write_addr, len, tag, select}, valid/ready
//   m_axis_desc_*                 per-engine descriptor out; data replicated, valid one-hot on the selected engine
//   s_axis_desc_status_*          per-engine {tag, error} status, valid only
//   m_axis_desc_status_*          merged status with originating engine index, one-cycle valid
//   stat_drop, stat_overflow      event pulses: out-of-range select, per-engine status loss
module axi_cdma_desc_demux
  import axi_cdma_desc_demux_pkg::*;
#(
  parameter int PORTS             = 2,
  parameter int AXI_ADDR_WIDTH    = 16,
  parameter int LEN_WIDTH         = 20,
  parameter int TAG_WIDTH         = 8,
  parameter int SEL_WIDTH         = sel_width(PORTS),
  parameter int STATUS_FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [AXI_ADDR_WIDTH-1:0]       s_axis_desc_read_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]       s_axis_desc_write_addr,
  input  logic [LEN_WIDTH-1:0]            s_axis_desc_len,
  input  logic [TAG_WIDTH-1:0]            s_axis_desc_tag,
  input  logic [SEL_WIDTH-1:0]            s_axis_desc_select,
  input  logic                            s_axis_desc_valid,
  output logic                            s_axis_desc_ready,
  output logic [PORTS*AXI_ADDR_WIDTH-1:0] m_axis_desc_read_addr,
  output logic [PORTS*AXI_ADDR_WIDTH-1:0] m_axis_desc_write_addr,
  output logic [PORTS*LEN_WIDTH-1:0]      m_axis_desc_len,
  output logic [PORTS*TAG_WIDTH-1:0]      m_axis_desc_tag,
  output logic [PORTS-1:0]                m_axis_desc_valid,
  input  logic [PORTS-1:0]                m_axis_desc_ready,
  input  logic [PORTS*TAG_WIDTH-1:0]      s_axis_desc_status_tag,
  input  logic [PORTS*STATUS_ERR_WIDTH-1:0] s_axis_desc_status_error,
  input  logic [PORTS-1:0]                s_axis_desc_status_valid,
  output logic [TAG_WIDTH-1:0]            m_axis_desc_status_tag,
  output logic [STATUS_ERR_WIDTH-1:0]     m_axis_desc_status_error,
  output logic [SEL_WIDTH-1:0]            m_axis_desc_status_port,
  output logic                            m_axis_desc_status_valid,
  output logic                            stat_drop,
  output logic [PORTS-1:0]                stat_overflow
);

  localparam int EW = status_entry_width(TAG_WIDTH);

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] rd_addr;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [LEN_WIDTH-1:0]      len;
    logic [TAG_WIDTH-1:0]      tag;
  } desc_t;

  // ---------------------------------------------------------------------
  // Descriptor path: output register plus temp (skid) register.
  // ---------------------------------------------------------------------
  desc_t                out_desc_q, out_desc_d;
  logic [SEL_WIDTH-1:0] out_sel_q, out_sel_d;
  logic                 out_valid_q, out_valid_d;
  desc_t                tmp_desc_q, tmp_desc_d;
  logic [SEL_WIDTH-1:0] tmp_sel_q, tmp_sel_d;
  logic                 tmp_valid_q, tmp_valid_d;
  logic                 s_ready_q, s_ready_d;
  logic                 drop_q, drop_d;

  desc_t                in_desc;
  logic                 in_acc;
  logic                 in_range;
  logic                 int_valid;
  logic                 out_ready;

  always_comb begin
    in_desc.rd_addr = s_axis_desc_read_addr;
    in_desc.wr_addr = s_axis_desc_write_addr;
    in_desc.len     = s_axis_desc_len;
    in_desc.tag     = s_axis_desc_tag;

    in_acc    = s_axis_desc_valid && s_ready_q;
    in_range  = int'(s_axis_desc_select) < PORTS;
    // Out-of-range descriptors are consumed here and never occupy a register.
    int_valid = in_acc && in_range;
    drop_d    = in_acc && !in_range;

    out_ready = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (out_sel_q == SEL_WIDTH'(i)) begin
        out_ready = out_valid_q && m_axis_desc_ready[i];
      end
    end

    out_desc_d  = out_desc_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    tmp_desc_d  = tmp_desc_q;
    tmp_sel_d   = tmp_sel_q;
    tmp_valid_d = tmp_valid_q;

    if (s_ready_q) begin
      // Input side open: the temp register is guaranteed empty here.
      if (out_ready || !out_valid_q) begin
        out_valid_d = int_valid;
        if (int_valid) begin
          out_desc_d = in_desc;
          out_sel_d  = s_axis_desc_select;
        end
      end else begin
        tmp_valid_d = int_valid;
        if (int_valid) begin
          tmp_desc_d = in_desc;
          tmp_sel_d  = s_axis_desc_select;
        end
      end
    end else if (out_ready) begin
      out_valid_d = tmp_valid_q;
      out_desc_d  = tmp_desc_q;
      out_sel_d   = tmp_sel_q;
      tmp_valid_d = 1'b0;
    end

    // Early ready: stay open unless the temp register is (or is about to be) occupied.
    s_ready_d = out_ready || (!tmp_valid_q && (!out_valid_q || !int_valid));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      tmp_valid_q <= 1'b0;
      s_ready_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      tmp_valid_q <= tmp_valid_d;
      s_ready_q   <= s_ready_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    out_desc_q <= out_desc_d;
    out_sel_q  <= out_sel_d;
    tmp_desc_q <= tmp_desc_d;
    tmp_sel_q  <= tmp_sel_d;
  end

  assign s_axis_desc_ready = s_ready_q;
  assign stat_drop         = drop_q;

  // Every engine sees the same data; only the selected one sees valid.
  for (genvar i = 0; i < PORTS; i++) begin : g_desc_out
    assign m_axis_desc_read_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]  = out_desc_q.rd_addr;
    assign m_axis_desc_write_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] = out_desc_q.wr_addr;
    assign m_axis_desc_len[i*LEN_WIDTH +: LEN_WIDTH]                  = out_desc_q.len;
    assign m_axis_desc_tag[i*TAG_WIDTH +: TAG_WIDTH]                  = out_desc_q.tag;
    assign m_axis_desc_valid[i] = out_valid_q && (out_sel_q == SEL_WIDTH'(i));
  end

  // ---------------------------------------------------------------------
  // Status path: per-engine FIFOs merged by a round-robin arbiter.
  // ---------------------------------------------------------------------
  logic [PORTS-1:0] fifo_empty;
  logic [PORTS-1:0] fifo_full;
  logic [PORTS-1:0] pop;
  logic [EW-1:0]    fifo_dout [PORTS];

  for (genvar i = 0; i < PORTS; i++) begin : g_status_fifo
    axi_cdma_status_fifo #(
      .DEPTH (STATUS_FIFO_DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_vld   (s_axis_desc_status_valid[i]),
      .wr_dat   ({s_axis_desc_status_tag[i*TAG_WIDTH +: TAG_WIDTH],
                  s_axis_desc_status_error[i*STATUS_ERR_WIDTH +: STATUS_ERR_WIDTH]}),
      .rd_en    (pop[i]),
      .rd_dat   (fifo_dout[i]),
      .empty    (fifo_empty[i]),
      .full     (fifo_full[i]),
      .overflow (stat_overflow[i])
    );
  end

  logic [SEL_WIDTH-1:0]        rr_q, rr_d;
  logic                        grant_vld;
  logic [SEL_WIDTH-1:0]        grant_idx;
  logic                        st_valid_q, st_valid_d;
  logic [TAG_WIDTH-1:0]        st_tag_q, st_tag_d;
  logic [STATUS_ERR_WIDTH-1:0] st_err_q, st_err_d;
  logic [SEL_WIDTH-1:0]        st_port_q, st_port_d;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    // First pass: requesters at or above the pointer; second pass wraps to the bottom.
    for (int i = 0; i < PORTS; i++) begin
      if (!grant_vld && !fifo_empty[i] && (SEL_WIDTH'(i) >= rr_q)) begin
        grant_vld = 1'b1;
        grant_idx = SEL_WIDTH'(i);
      end
    end
    for (int i = 0; i < PORTS; i++) begin
      if (!grant_vld && !fifo_empty[i]) begin
        grant_vld = 1'b1;
        grant_idx = SEL_WIDTH'(i);
      end
    end

    pop = '0;
    for (int i = 0; i < PORTS; i++) begin
      pop[i] = grant_vld && (grant_idx == SEL_WIDTH'(i));
    end

    rr_d = rr_q;
    if (grant_vld) begin
      rr_d = (int'(grant_idx) == PORTS - 1) ? '0 : grant_idx + SEL_WIDTH'(1);
    end

    st_valid_d = grant_vld;
    st_tag_d   = st_tag_q;
    st_err_d   = st_err_q;
    st_port_d  = st_port_q;
    for (int i = 0; i < PORTS; i++) begin
      if (pop[i]) begin
        {st_tag_d, st_err_d} = fifo_dout[i];
        st_port_d            = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      st_valid_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      st_valid_q <= st_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    st_tag_q  <= st_tag_d;
    st_err_q  <= st_err_d;
    st_port_q <= st_port_d;
  end

  assign m_axis_desc_status_valid = st_valid_q;
  assign m_axis_desc_status_tag   = st_tag_q;
  assign m_axis_desc_status_error = st_err_q;
  assign m_axis_desc_status_port  = st_port_q;

endmodule

// File: tb/tb_axi_cdma_desc_demux.sv
module tb_axi_cdma_desc_demux;
  import axi_cdma_desc_demux_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_ra = '0, s_wa = '0;
  logic [19:0] s_len = '0;
  logic [7:0]  s_tag = '0;
  logic [1:0]  s_sel = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_ra, m_wa;
  logic [39:0] m_len;
  logic [15:0] m_tag;
  logic [1:0]  m_valid;
  logic [1:0]  m_ready = 2'b11;
  logic [15:0] st_in_tag = '0;
  logic [7:0]  st_in_err = '0;
  logic [1:0]  st_in_valid = '0;
  logic [7:0]  st_tag;
  logic [3:0]  st_err;
  logic [1:0]  st_port;
  logic        st_valid;
  logic        stat_drop;
  logic [1:0]  stat_overflow;

  axi_cdma_desc_demux #(
    .PORTS(2), .AXI_ADDR_WIDTH(16), .LEN_WIDTH(20), .TAG_WIDTH(8),
    .SEL_WIDTH(2), .STATUS_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_desc_read_addr(s_ra), .s_axis_desc_write_addr(s_wa),
    .s_axis_desc_len(s_len), .s_axis_desc_tag(s_tag),
    .s_axis_desc_select(s_sel), .s_axis_desc_valid(s_valid),
    .s_axis_desc_ready(s_ready),
    .m_axis_desc_read_addr(m_ra), .m_axis_desc_write_addr(m_wa),
    .m_axis_desc_len(m_len), .m_axis_desc_tag(m_tag),
    .m_axis_desc_valid(m_valid), .m_axis_desc_ready(m_ready),
    .s_axis_desc_status_tag(st_in_tag), .s_axis_desc_status_error(st_in_err),
    .s_axis_desc_status_valid(st_in_valid),
    .m_axis_desc_status_tag(st_tag), .m_axis_desc_status_error(st_err),
    .m_axis_desc_status_port(st_port), .m_axis_desc_status_valid(st_valid),
    .stat_drop(stat_drop), .stat_overflow(stat_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [1:0]  port;
    logic [15:0] ra;
    logic [15:0] wa;
    logic [19:0] len;
    logic [7:0]  tag;
  } desc_exp_t;

  typedef struct {
    logic [1:0] port;
    logic [7:0] tag;
    logic [3:0] err;
    int         cyc;
  } st_exp_t;

  desc_exp_t dq[$];
  st_exp_t   sq[$];
  int        hs_cyc[$];
  int        drop_cnt = 0;
  int        ovf_cnt[2] = '{0, 0};
  int        st_cnt[2] = '{0, 0};
  desc_exp_t de;
  st_exp_t   se;

  // Monitor: compares every descriptor handshake and merged status against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        if (m_valid[p] && m_ready[p]) begin
          hs_cyc.push_back(cyc);
          if (dq.size() == 0) begin
            checks++;
            $display("FAIL desc_unexpected: port %0d tag 0x%0h with nothing expected", p, m_tag[p*8 +: 8]);
          end else begin
            de = dq.pop_front();
            check("desc_port", p, de.port);
            check("desc_onehot", m_valid, 2'b01 << p);
            check("desc_ra", m_ra[p*16 +: 16], de.ra);
            check("desc_wa", m_wa[p*16 +: 16], de.wa);
            check("desc_len", m_len[p*20 +: 20], de.len);
            check("desc_tag", m_tag[p*8 +: 8], de.tag);
          end
        end
      end
      if (st_valid) begin
        st_cnt[st_port[0]]++;
        if (sq.size() == 0) begin
          checks++;
          $display("FAIL status_unexpected: port %0d tag 0x%0h with nothing expected", st_port, st_tag);
        end else begin
          se = sq.pop_front();
          check("status_port", st_port, se.port);
          check("status_tag", st_tag, se.tag);
          check("status_err", st_err, se.err);
          if (se.cyc >= 0) check("status_latency", cyc, se.cyc);
        end
      end
      if (stat_drop) drop_cnt++;
      for (int p = 0; p < 2; p++) if (stat_overflow[p]) ovf_cnt[p]++;
    end
  end

  task automatic send(input logic [15:0] ra, input logic [15:0] wa, input logic [19:0] ln,
                      input logic [7:0] tg, input logic [1:0] sel, input bit expect_out);
    int t;
    desc_exp_t e;
    s_ra = ra; s_wa = wa; s_len = ln; s_tag = tg; s_sel = sel; s_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      checks++;
      $display("FAIL send_timeout: s_axis_desc_ready still 0, required 1 (tag 0x%0h)", tg);
    end else if (expect_out) begin
      e.port = sel; e.ra = ra; e.wa = wa; e.len = ln; e.tag = tg;
      dq.push_back(e);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic push_st(input logic [1:0] port, input logic [7:0] tag, input logic [3:0] err, input int c);
    st_exp_t e;
    e.port = port; e.tag = tag; e.err = err; e.cyc = c;
    sq.push_back(e);
  endtask

  initial begin
    int c;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_status_valid", st_valid, 0);
    check("rst_stat_drop", stat_drop, 0);
    check("rst_stat_overflow", stat_overflow, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_before_first_edge", s_ready, 0);
    @(negedge clk);
    check("ready_after_reset", s_ready, 1);

    // Single descriptor to engine 1
    @(posedge clk); #1;
    send(16'h1000, 16'h2000, 20'd64, 8'h11, 2'd1, 1'b1);
    @(negedge clk);
    check("first_desc_valid", m_valid, 2'b10);

    // Back-to-back 0,1,0 with no bubbles
    @(posedge clk); #1;
    hs_cyc.delete();
    send(16'h0100, 16'h0200, 20'd1, 8'h21, 2'd0, 1'b1);
    send(16'h0110, 16'h0210, 20'd2, 8'h22, 2'd1, 1'b1);
    send(16'h0120, 16'h0220, 20'd3, 8'h23, 2'd0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("b2b_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      check("b2b_gap0", hs_cyc[1] - hs_cyc[0], 1);
      check("b2b_gap1", hs_cyc[2] - hs_cyc[1], 1);
    end

    // Engine 0 stalled: skid register fills, ready drops, order kept on release
    @(posedge clk); #1;
    m_ready = 2'b10;
    send(16'h3000, 16'h4000, 20'd128, 8'h31, 2'd0, 1'b1);
    send(16'h3100, 16'h4100, 20'd256, 8'h32, 2'd0, 1'b1);
    @(negedge clk);
    check("stall_ready_low", s_ready, 0);
    check("stall_m_valid", m_valid, 2'b01);
    @(posedge clk); #1;
    m_ready = 2'b11;
    repeat (4) @(negedge clk);
    #1;
    check("stall_drained", dq.size(), 0);
    check("stall_ready_back", s_ready, 1);

    // Out-of-range select is swallowed with a drop pulse
    drop_cnt = 0;
    @(posedge clk); #1;
    send(16'h5000, 16'h6000, 20'd8, 8'h55, 2'd3, 1'b0);
    @(negedge clk);
    check("drop_pulse", stat_drop, 1);
    check("drop_no_valid", m_valid, 0);
    @(negedge clk);
    check("drop_pulse_end", stat_drop, 0);
    #1;
    check("drop_count", drop_cnt, 1);

    // Simultaneous status from both engines
    @(posedge clk); #1;
    c = cyc;
    push_st(2'd0, 8'hA0, DMA_ERROR_NONE, c + 2);
    push_st(2'd1, 8'hB1, DMA_ERROR_NONE, c + 3);
    st_in_tag = {8'hB1, 8'hA0}; st_in_err = 8'h00; st_in_valid = 2'b11;
    @(posedge clk); #1;
    st_in_valid = 2'b00;
    repeat (5) @(negedge clk);
    #1;
    check("pair_drained", sq.size(), 0);

    // Flood: both engines every cycle for 10 cycles; engine 0 loses k=8, engine 1 loses k=7,9
    ovf_cnt = '{0, 0};
    st_cnt = '{0, 0};
    for (int i = 0; i < 9; i++) begin
      push_st(2'd0, (i < 8) ? 8'(i) : 8'd9, 4'h0, -1);
      if (i < 8) push_st(2'd1, (i < 7) ? 8'(8'h80 + i) : 8'h88, (i < 7) ? 4'(i) : 4'd8, -1);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      st_in_tag = {8'(8'h80 + k), 8'(k)};
      st_in_err = {4'(k), 4'h0};
      st_in_valid = 2'b11;
      @(posedge clk); #1;
    end
    st_in_valid = 2'b00;
    repeat (25) @(negedge clk);
    #1;
    check("flood_drained", sq.size(), 0);
    check("flood_ovf0", ovf_cnt[0], 1);
    check("flood_ovf1", ovf_cnt[1], 2);
    check("flood_sum1", st_cnt[1] + ovf_cnt[1], 10);
    check("flood_sum0", st_cnt[0] + ovf_cnt[0], 10);

    // Reset mid-operation discards queued descriptors and statuses
    @(posedge clk); #1;
    m_ready = 2'b10;
    send(16'h7000, 16'h8000, 20'd4, 8'h71, 2'd0, 1'b0);
    send(16'h7100, 16'h8100, 20'd4, 8'h72, 2'd0, 1'b0);
    st_in_tag = 16'h00C0; st_in_err = 8'h01; st_in_valid = 2'b01;
    @(posedge clk); #1;
    st_in_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_status_valid", st_valid, 0);
    check("midrst_s_ready", s_ready, 0);
    @(posedge clk); #1;
    m_ready = 2'b11;
    repeat (6) @(negedge clk);
    check("midrst_ready_back", s_ready, 1);
    check("midrst_no_desc_left", dq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
